// File: rtl/ifid_hazard_stage_pkg.sv
// Shared constants and types for the IF/ID stage: opcodes, NOP word, stall FSM states.
// No logic beyond the rt-usage decode helper.
package ifid_hazard_stage_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [31:0] NOP      = 32'h0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Only these formats read rt as a source; everything else writes it.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/ifid_hazard_stage_if.sv
// Fetch-side, ID/EX-feedback and IF/ID-output bundle of the IF/ID stage.
// slave = the stage itself, master = whoever drives fetch and observes the stage.
interface ifid_hazard_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_plus4_in;
  logic [XLEN-1:0] instr_in;
  logic            if_valid_in;
  logic            branch_taken_in;
  logic            ext_stall_in;
  logic            idex_mem_read_in;
  logic [4:0]      idex_rt_in;

  logic [XLEN-1:0] ifid_pc_out;
  logic [XLEN-1:0] ifid_instr_out;
  logic            ifid_valid_out;
  logic            pc_write_en_out;
  logic            idex_bubble_out;
  logic            stall_out;

  modport master (
    output pc_plus4_in, instr_in, if_valid_in, branch_taken_in, ext_stall_in,
           idex_mem_read_in, idex_rt_in,
    input  ifid_pc_out, ifid_instr_out, ifid_valid_out, pc_write_en_out,
           idex_bubble_out, stall_out
  );

  modport slave (
    input  pc_plus4_in, instr_in, if_valid_in, branch_taken_in, ext_stall_in,
           idex_mem_read_in, idex_rt_in,
    output ifid_pc_out, ifid_instr_out, ifid_valid_out, pc_write_en_out,
           idex_bubble_out, stall_out
  );
endinterface

// File: rtl/ifid_hazard_stage_hazard_detect.sv
// Load-use hazard compare between the IF/ID instruction and the load in ID/EX.
// Purely combinational, zero latency; no handshake.
module hazard_detect
  import ifid_hazard_stage_pkg::*;
(
  input  logic [15:0] instr_hi,
  input  logic        valid,
  input  logic        mem_read,
  input  logic [4:0]  idex_rt,
  output logic        hazard
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;

  always_comb begin
    opcode = instr_hi[15:10];
    rs     = instr_hi[9:5];
    rt     = instr_hi[4:0];
    // $zero never carries a real dependency
    hazard = valid && mem_read && (idex_rt != 5'd0) &&
             ((idex_rt == rs) || (uses_rt(opcode) && (idex_rt == rt)));
  end

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use stall FSM, branch flush and external freeze; 1-cycle latency.
// Backpressure via ext_stall_in (full hold) and load-use (hold + bubble); IFID_PERF_CNT_EN adds saturating counters.
module ifid_hazard_stage
  import ifid_hazard_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef IFID_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt_out,
  output logic [CNT_W-1:0]  flush_cnt_out,
`endif
  ifid_hazard_stage_if.slave bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            hazard;
  logic            pc_write_en;
  logic            idex_bubble;
  logic            stall;

  hazard_detect u_hazard_detect (
    .instr_hi (ifid_instr_q[31:16]),
    .valid    (ifid_valid_q),
    .mem_read (bus.idex_mem_read_in),
    .idex_rt  (bus.idex_rt_in),
    .hazard   (hazard)
  );

  always_comb begin
    state_d      = state_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    pc_write_en  = 1'b1;
    idex_bubble  = 1'b0;
    stall        = 1'b0;

    if (bus.branch_taken_in) begin
      ifid_instr_d = XLEN'(NOP);
      ifid_valid_d = 1'b0;
      state_d      = RUN;
    end else if (bus.ext_stall_in) begin
      pc_write_en = 1'b0;
    end else if ((state_q == RUN) && hazard) begin
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
      stall       = 1'b1;
      state_d     = STALL;
    end else begin
      // STALL lasts one cycle: the bubble now in ID/EX has cleared memRead
      ifid_pc_d    = bus.pc_plus4_in;
      ifid_instr_d = bus.instr_in;
      ifid_valid_d = bus.if_valid_in;
      state_d      = RUN;
    end

    if (!rst_n) begin
      pc_write_en = 1'b1;
      idex_bubble = 1'b0;
      stall       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.ifid_pc_out     = ifid_pc_q;
  assign bus.ifid_instr_out  = ifid_instr_q;
  assign bus.ifid_valid_out  = ifid_valid_q;
  assign bus.pc_write_en_out = pc_write_en;
  assign bus.idex_bubble_out = idex_bubble;
  assign bus.stall_out       = stall;

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (bus.branch_taken_in && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: doc/ifid_hazard_stage.md
IFID_HAZARD_STAGE -- requirements
Module: ifid_hazard_stage

Interface
REQ-001 Parameter XLEN, default 32: PC and instruction width in bits.
REQ-002 Parameter CNT_W, default 16: performance counter width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_plus4_in  input  XLEN  PC+4 from the fetch stage.
REQ-006 instr_in  input  XLEN  fetched instruction word.
REQ-007 if_valid_in  input  1  fetch output is a real instruction.
REQ-008 branch_taken_in  input  1  branch resolved taken; the younger instruction must be flushed.
REQ-009 ext_stall_in  input  1  downstream freeze request, e.g. a memory wait.
REQ-010 idex_mem_read_in  input  1  memRead flag currently held in the ID/EX register.
REQ-011 idex_rt_in  input  5  rt field (bits 20:16) currently held in the ID/EX register.
REQ-012 ifid_pc_out  output  XLEN  registered PC+4 to decode and ID/EX.
REQ-013 ifid_instr_out  output  XLEN  registered instruction to decode.
REQ-014 ifid_valid_out  output  1  registered instruction is valid.
REQ-015 pc_write_en_out  output  1  PC register may update.
REQ-016 idex_bubble_out  output  1  ID/EX must capture all-zero control flags this cycle.
REQ-017 stall_out  output  1  a load-use stall is active.
REQ-018 stall_cnt_out  output  CNT_W  load-use stall cycle count; present only with the macro in REQ-034.
REQ-019 flush_cnt_out  output  CNT_W  flush event count; present only with the macro in REQ-034.

Function
REQ-020 The stage SHALL register the instruction and PC with one-cycle latency: inputs sampled at edge N appear on the outputs after edge N.
REQ-021 Source fields: rs = ifid_instr_out[25:21], rt = ifid_instr_out[20:16], opcode = ifid_instr_out[31:26].
REQ-022 rt is used when opcode is 6'h00 (R-type), 6'h04 (beq) or 6'h2B (sw); otherwise only rs is compared.
REQ-023 A hazard exists when all of the following hold:
- ifid_valid_out = 1
- idex_mem_read_in = 1
- idex_rt_in != 0
- idex_rt_in equals rs, or idex_rt_in equals rt and rt is used.
REQ-024 FSM state RUN: when a hazard exists and branch_taken_in = 0, the FSM SHALL go to STALL.
REQ-025 FSM state STALL: the FSM SHALL return to RUN after exactly one cycle, because the injected bubble clears idex_mem_read_in.
REQ-026 While a hazard exists in RUN, the stage SHALL combinationally drive:
- pc_write_en_out = 0
- idex_bubble_out = 1
- stall_out = 1
- IF/ID registers held unchanged.
REQ-027 When branch_taken_in = 1, the next edge SHALL load instr 32'h0 and valid 0, keep the PC value unchanged, drive pc_write_en_out = 1, and force the FSM to RUN.
REQ-028 Priority SHALL be reset > branch flush > ext_stall_in > load-use hazard > normal advance.
REQ-029 When ext_stall_in = 1 and no flush, all registers and the FSM SHALL hold, pc_write_en_out = 0, and idex_bubble_out = 0.
REQ-030 Normal advance SHALL load pc_plus4_in, instr_in and if_valid_in, with pc_write_en_out = 1.
REQ-031 When if_valid_in = 0 with no stall and no flush, the stage SHALL load valid 0; the captured instruction is don't-care.

Reset
REQ-032 While rst_n = 0, all of the following SHALL hold asynchronously:
- ifid_pc_out = 0, ifid_instr_out = 0, ifid_valid_out = 0
- FSM = RUN
- counters = 0.
REQ-033 During reset, pc_write_en_out = 1, idex_bubble_out = 0 and stall_out = 0; reset mid-stall aborts the stall with no residual hold after release.

Configuration
REQ-034 With IFID_PERF_CNT_EN defined, the counters SHALL behave as follows:
- stall_cnt_out increments each cycle stall_out = 1.
- flush_cnt_out increments on each edge where branch_taken_in = 1.
- Both saturate at all-ones and never wrap.
REQ-035 Without IFID_PERF_CNT_EN, the counter ports and their logic SHALL be absent.

Structure
REQ-036 A shared package SHALL hold:
- the opcode constants OP_RTYPE, OP_BEQ, OP_SW
- the NOP constant 32'h0
- the FSM state typedef (RUN, STALL).
REQ-037 Hazard comparison SHALL be a sub-module, hazard_detect, which is purely combinational; the registers and FSM stay in ifid_hazard_stage.

Verification
REQ-038 Normal flow: instr_in = 32'h8C0A0004 (lw $10), if_valid_in = 1, idle ID/EX -> next cycle ifid_instr_out = 32'h8C0A0004, valid 1, stall_out 0.
REQ-039 Load-use hazard: ID/EX idex_mem_read_in = 1, idex_rt_in = 10; IF/ID holds add $3,$10,$4 (32'h01441820):
- stall_out = 1 for exactly one cycle
- pc_write_en_out = 0 and idex_bubble_out = 1 in that cycle
- IF/ID holds 32'h01441820.
REQ-040 No hazard: idex_rt_in = 0 with idex_mem_read_in = 1 -> no stall; and rt match with opcode 6'h08 (addi) -> no stall.
REQ-041 Flush during hazard: branch_taken_in = 1 in the same cycle as a hazard -> next edge ifid_valid_out = 0, ifid_instr_out = 0, stall_out = 0, FSM = RUN.
REQ-042 External stall: ext_stall_in = 1 for 3 cycles -> outputs frozen and pc_write_en_out = 0 for 3 cycles, then the stage resumes with the held instruction.
REQ-043 Async reset and counters: rst_n pulled low mid-cycle during STALL -> outputs zero immediately; with IFID_PERF_CNT_EN and CNT_W = 2, four stalls -> stall_cnt_out = 3 (saturated).
